// File: rtl/cmsdk_apb4_eg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmsdk_apb4_eg_pkg
// Description : Shared types, defaults and helpers for the APB4 wait-state
//               slave interface.
// Revision    : 1.0
// ============================================================================
package cmsdk_apb4_eg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_LIMIT = 32'h400;
  localparam int          DEF_TIMEOUT    = 16;

  // Wait counter must hold values 0..timeout; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmsdk_apb4_eg_slave_interface_ws_if.sv
`default_nettype none
// ============================================================================
// Module      : cmsdk_apb4_eg_slave_interface_ws_if
// Description : APB4 bus plus register request/acknowledge bundle.
// Revision    : 1.0
// ============================================================================
interface cmsdk_apb4_eg_slave_interface_ws_if #(
  parameter int ADDRWIDTH = 12
);
  logic                 psel;
  logic [ADDRWIDTH-1:0] paddr;
  logic                 penable;
  logic                 pwrite;
  logic [31:0]          pwdata;
  logic [3:0]           pstrb;
  logic [2:0]           pprot;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;
  logic [ADDRWIDTH-1:0] addr;
  logic                 read_en;
  logic                 write_en;
  logic [3:0]           byte_strobe;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 reg_ready;
  logic                 reg_err;

  modport slave (
    input  psel, paddr, penable, pwrite, pwdata, pstrb, pprot,
    input  rdata, reg_ready, reg_err,
    output prdata, pready, pslverr,
    output addr, read_en, write_en, byte_strobe, wdata
  );

  modport master (
    output psel, paddr, penable, pwrite, pwdata, pstrb, pprot,
    output rdata, reg_ready, reg_err,
    input  prdata, pready, pslverr,
    input  addr, read_en, write_en, byte_strobe, wdata
  );

endinterface
`default_nettype wire

// File: rtl/cmsdk_apb4_eg_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : cmsdk_apb4_eg_wait_timer
// Description : Loadable wait-state counter with timeout compare.
// Revision    : 1.0
// ============================================================================
module cmsdk_apb4_eg_wait_timer
  import cmsdk_apb4_eg_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic start_i,
  input  wire logic enable_i,
  output logic      expired_o
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Loading 1 marks the first WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CW'(1);
    end else if (enable_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/cmsdk_apb4_eg_slave_interface_ws.sv
`default_nettype none
// ============================================================================
// Module      : cmsdk_apb4_eg_slave_interface_ws
// Description : APB4 slave front-end to a req/ack register bank with wait
//               states, timeout, decode and privilege errors.
// Revision    : 1.0
// ============================================================================
module cmsdk_apb4_eg_slave_interface_ws
  import cmsdk_apb4_eg_pkg::*;
#(
  parameter int          ADDRWIDTH  = 12,
  parameter int unsigned ADDR_LIMIT = DEF_ADDR_LIMIT,
  parameter int          TIMEOUT    = DEF_TIMEOUT,
  parameter int          PRIV_ONLY  = 0
) (
  input wire logic pclk,
  input wire logic preset,
  cmsdk_apb4_eg_slave_interface_ws_if.slave bus
);

  state_e               state_q;
  logic                 pwrite_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           strb_q;
  logic                 read_en_q;
  logic                 write_en_q;
  logic                 pready_q;
  logic                 pslverr_q;
  logic [31:0]          prdata_q;

  logic w_dec_err;
  logic w_start;
  logic w_enable;
  logic w_expired;
  logic w_unused_pprot;

  assign w_dec_err = (32'(bus.paddr) >= ADDR_LIMIT) ||
                     ((PRIV_ONLY != 0) && !bus.pprot[0]);
  assign w_unused_pprot = ^bus.pprot[2:1];

  assign w_start  = (state_q == ST_REQ)  && bus.psel && !bus.reg_ready;
  assign w_enable = (state_q == ST_WAIT) && bus.psel && !bus.reg_ready && !w_expired;

  cmsdk_apb4_eg_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (pclk),
    .rst_i     (preset),
    .start_i   (w_start),
    .enable_i  (w_enable),
    .expired_o (w_expired)
  );

  // pslverr_q doubles as the error flag: it is only ever visible in RESP.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      pwrite_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.psel && !bus.penable) begin
            addr_q   <= bus.paddr;
            pwrite_q <= bus.pwrite;
            wdata_q  <= bus.pwdata;
            strb_q   <= bus.pwrite ? bus.pstrb : 4'b0000;
            if (w_dec_err) begin
              state_q   <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else begin
              state_q    <= ST_REQ;
              read_en_q  <= !bus.pwrite;
              write_en_q <= bus.pwrite;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          // Abort takes priority; a late reg_ready then lands in IDLE and is ignored.
          if (!bus.psel) begin
            state_q <= ST_IDLE;
          end else if (bus.reg_ready) begin
            state_q   <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= bus.reg_err;
            prdata_q  <= (!pwrite_q && !bus.reg_err) ? bus.rdata : 32'h0;
          end else if ((state_q == ST_WAIT) && w_expired) begin
            state_q   <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end else if (state_q == ST_REQ) begin
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.prdata      = prdata_q;
  assign bus.pready      = pready_q;
  assign bus.pslverr     = pslverr_q;
  assign bus.addr        = addr_q;
  assign bus.read_en     = read_en_q;
  assign bus.write_en    = write_en_q;
  assign bus.byte_strobe = strb_q;
  assign bus.wdata       = wdata_q;

`ifdef ARM_APB_ASSERT_ON
  a_err_needs_ready: assert property (@(posedge pclk) disable iff (preset)
    pslverr_q |-> pready_q);
  a_req_exclusive: assert property (@(posedge pclk) disable iff (preset)
    !(read_en_q && write_en_q));
  a_req_single: assert property (@(posedge pclk) disable iff (preset)
    (read_en_q || write_en_q) |=> !(read_en_q || write_en_q));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_apb4_eg_slave_interface_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmsdk_apb4_eg_slave_interface_ws
// Description : Two-instance bench (default config and PRIV_ONLY/short
//               timeout) sharing one stimulus stream, checked against a
//               transfer-level response model.
// Revision    : 1.0
// ============================================================================
module tb_cmsdk_apb4_eg_slave_interface_ws;

  localparam int TMO_A = 16;
  localparam int TMO_B = 2;
  localparam int MAX_CYC = 40;

  logic pclk = 1'b0;
  logic preset;
  int   checks   = 0;
  int   failures = 0;

  cmsdk_apb4_eg_slave_interface_ws_if #(.ADDRWIDTH(12)) ifa ();
  cmsdk_apb4_eg_slave_interface_ws_if #(.ADDRWIDTH(12)) ifb ();

  assign ifb.psel      = ifa.psel;
  assign ifb.paddr     = ifa.paddr;
  assign ifb.penable   = ifa.penable;
  assign ifb.pwrite    = ifa.pwrite;
  assign ifb.pwdata    = ifa.pwdata;
  assign ifb.pstrb     = ifa.pstrb;
  assign ifb.pprot     = ifa.pprot;
  assign ifb.rdata     = ifa.rdata;
  assign ifb.reg_ready = ifa.reg_ready;
  assign ifb.reg_err   = ifa.reg_err;

  always #5 pclk = ~pclk;

  cmsdk_apb4_eg_slave_interface_ws #(
    .ADDRWIDTH (12), .ADDR_LIMIT (32'h400), .TIMEOUT (TMO_A), .PRIV_ONLY (0)
  ) dut_a (.pclk (pclk), .preset (preset), .bus (ifa));

  cmsdk_apb4_eg_slave_interface_ws #(
    .ADDRWIDTH (12), .ADDR_LIMIT (32'h400), .TIMEOUT (TMO_B), .PRIV_ONLY (1)
  ) dut_b (.pclk (pclk), .preset (preset), .bus (ifb));

  typedef struct packed {
    int          lat;
    logic        err;
    logic [31:0] rd;
    logic        req;
  } exp_t;

  // d: cycles after the first access cycle at which reg_ready arrives (-1 = never).
  function automatic exp_t model(input int tmo, input bit priv, input logic [11:0] a,
                                 input bit wr, input logic [2:0] prot, input int d,
                                 input bit rerr, input logic [31:0] rd);
    exp_t e;
    e = '0;
    if (a >= 12'h400 || (priv && !prot[0])) begin
      e.lat = 1;
      e.err = 1'b1;
    end else begin
      e.req = 1'b1;
      if (d >= 0 && (tmo == 0 || d <= tmo)) begin
        e.lat = d + 2;
        e.err = rerr;
        e.rd  = (!wr && !rerr) ? rd : 32'h0;
      end else begin
        e.lat = tmo + 2;
        e.err = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag, input logic pr, input logic ps, input logic re,
                            input logic we, input logic [11:0] ad, input logic [31:0] wd,
                            input logic [3:0] bs, input logic [31:0] pd);
    check({tag, "_ctl"}, 32'({pr, ps, re, we}), 32'h0);
    check({tag, "_addr"}, 32'(ad), 32'h0);
    check({tag, "_wdata"}, wd, 32'h0);
    check({tag, "_strb"}, 32'(bs), 32'h0);
    check({tag, "_prdata"}, pd, 32'h0);
  endtask

  task automatic drive_setup(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                             input logic [3:0] st, input logic [2:0] prot);
    ifa.psel = 1'b1; ifa.penable = 1'b0; ifa.paddr = a; ifa.pwrite = wr;
    ifa.pwdata = wd; ifa.pstrb = st; ifa.pprot = prot;
    ifa.reg_ready = 1'b0; ifa.reg_err = 1'b0; ifa.rdata = $urandom;
  endtask

  task automatic xfer(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] prot, input int d,
                      input bit rerr, input logic [31:0] rd);
    exp_t ea, eb;
    int   nra, nrb;
    bit   da, db;
    ea = model(TMO_A, 1'b0, a, wr, prot, d, rerr, rd);
    eb = model(TMO_B, 1'b1, a, wr, prot, d, rerr, rd);
    nra = 0; nrb = 0; da = 1'b0; db = 1'b0;
    @(negedge pclk);
    drive_setup(a, wr, wd, st, prot);
    for (int k = 1; k <= MAX_CYC && !(da && db); k++) begin
      @(negedge pclk);
      nra += int'(ifa.read_en) + int'(ifa.write_en);
      nrb += int'(ifb.read_en) + int'(ifb.write_en);
      if (k == 1 && ea.req) begin
        check("a_req_dir", 32'({ifa.write_en, ifa.read_en}), 32'({wr, !wr}));
        check("a_addr", 32'(ifa.addr), 32'(a));
        check("a_strb", 32'(ifa.byte_strobe), 32'(wr ? st : 4'b0000));
        if (wr) check("a_wdata", ifa.wdata, wd);
      end
      if (k == 1 && eb.req)
        check("b_req_dir", 32'({ifb.write_en, ifb.read_en}), 32'({wr, !wr}));
      if (k == 1 && ea.lat > 1)
        check("a_prdata_idle", ifa.prdata, 32'h0);
      if (!da && ifa.pready) begin
        da = 1'b1;
        check("a_lat", 32'(k), 32'(ea.lat));
        check("a_pslverr", 32'(ifa.pslverr), 32'(ea.err));
        check("a_prdata", ifa.prdata, ea.rd);
      end
      if (!db && ifb.pready) begin
        db = 1'b1;
        check("b_lat", 32'(k), 32'(eb.lat));
        check("b_pslverr", 32'(ifb.pslverr), 32'(eb.err));
        check("b_prdata", ifb.prdata, eb.rd);
      end
      ifa.penable   = 1'b1;
      ifa.reg_ready = (d >= 0 && k == d + 1);
      ifa.reg_err   = rerr;
      ifa.rdata     = ifa.reg_ready ? rd : $urandom;
    end
    check("a_completed", 32'(da), 32'h1);
    check("b_completed", 32'(db), 32'h1);
    check("a_req_count", 32'(nra), 32'(ea.req));
    check("b_req_count", 32'(nrb), 32'(eb.req));
  endtask

  task automatic abort_xfer();
    @(negedge pclk);
    drive_setup(12'h030, 1'b0, 32'h0, 4'hF, 3'b001);
    @(negedge pclk);
    ifa.penable = 1'b1;
    @(negedge pclk);
    ifa.psel = 1'b0; ifa.penable = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge pclk);
      check("abort_a_pready", 32'(ifa.pready), 32'h0);
      check("abort_b_pready", 32'(ifb.pready), 32'h0);
      ifa.reg_ready = (k == 3);
      ifa.rdata     = 32'h600DF00D;
    end
    ifa.reg_ready = 1'b0;
  endtask

  task automatic reset_mid_xfer();
    @(negedge pclk);
    drive_setup(12'h040, 1'b1, 32'h13572468, 4'hC, 3'b001);
    @(negedge pclk);
    ifa.penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    check_zero("rstmid_a", ifa.pready, ifa.pslverr, ifa.read_en, ifa.write_en,
               ifa.addr, ifa.wdata, ifa.byte_strobe, ifa.prdata);
    check_zero("rstmid_b", ifb.pready, ifb.pslverr, ifb.read_en, ifb.write_en,
               ifb.addr, ifb.wdata, ifb.byte_strobe, ifb.prdata);
    preset = 1'b0;
    ifa.psel = 1'b0; ifa.penable = 1'b0;
  endtask

  initial begin
    preset = 1'b1;
    ifa.psel = 1'b0; ifa.penable = 1'b0; ifa.paddr = '0; ifa.pwrite = 1'b0;
    ifa.pwdata = '0; ifa.pstrb = '0; ifa.pprot = '0;
    ifa.rdata = '0; ifa.reg_ready = 1'b0; ifa.reg_err = 1'b0;
    repeat (3) @(negedge pclk);
    check_zero("rst_a", ifa.pready, ifa.pslverr, ifa.read_en, ifa.write_en,
               ifa.addr, ifa.wdata, ifa.byte_strobe, ifa.prdata);
    check_zero("rst_b", ifb.pready, ifb.pslverr, ifb.read_en, ifb.write_en,
               ifb.addr, ifb.wdata, ifb.byte_strobe, ifb.prdata);
    preset = 1'b0;

    xfer(12'h010, 1'b0, 32'h0, 4'hF, 3'b001, 0, 1'b0, 32'hDEADBEEF);
    xfer(12'h024, 1'b1, 32'hA5A50001, 4'b0011, 3'b001, 2, 1'b0, 32'h0);
    xfer(12'h030, 1'b0, 32'h0, 4'h0, 3'b001, -1, 1'b0, 32'h12345678);
    xfer(12'h400, 1'b0, 32'h0, 4'h0, 3'b001, 0, 1'b0, 32'h11111111);
    xfer(12'h020, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hCAFEF00D);
    xfer(12'h3FC, 1'b0, 32'h0, 4'h0, 3'b001, TMO_A, 1'b0, 32'h0BADC0DE);
    xfer(12'h044, 1'b0, 32'h0, 4'h0, 3'b001, TMO_B, 1'b0, 32'h55AA55AA);
    xfer(12'h048, 1'b0, 32'h0, 4'h0, 3'b001, 1, 1'b1, 32'h77777777);
    abort_xfer();
    xfer(12'h050, 1'b0, 32'h0, 4'h0, 3'b001, 0, 1'b0, 32'h89ABCDEF);
    reset_mid_xfer();
    xfer(12'h054, 1'b1, 32'h2468ACE0, 4'b1010, 3'b001, 1, 1'b0, 32'h0);

    for (int i = 0; i < 24; i++) begin
      int r, d;
      r = int'($urandom_range(0, 7));
      d = (r == 0) ? -1 : (r == 1) ? TMO_A : (r == 2) ? TMO_A + 1 : r - 3;
      xfer(12'($urandom_range(0, 12'h47F)), 1'($urandom_range(0, 1)), $urandom,
           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), d,
           1'($urandom_range(0, 3) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
